// File: rtl/mf8_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mf8_uart_pkg
// Purpose  : Shared receiver state encoding, status bit indices and default
//            IO addresses for the MF8 UART peripherals and IO decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mf8_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int c_STAT_AVAIL = 0;
    localparam int c_STAT_FULL  = 1;
    localparam int c_STAT_OVR   = 2;
    localparam int c_STAT_FE    = 3;
    localparam int c_STAT_PE    = 4;
    localparam int c_STAT_BUSY  = 7;

    localparam logic [5:0] c_ADDR_DATA = 6'h00;
    localparam logic [5:0] c_ADDR_STAT = 6'h01;

endpackage
`default_nettype wire

// File: rtl/mf8_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mf8_sync_fifo
// Purpose  : Small synchronous FIFO, registered full/empty flags; push when
//            full (without a same-cycle pop) and pop when empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mf8_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             Reset_s_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int c_DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_wptr_nxt;
    logic [AW:0]      w_rptr_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign w_do_pop   = pop && !r_empty;
    assign w_do_push  = push && (!r_full || w_do_pop);
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_do_push};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_do_pop};

    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= push_data;
        end
    end

    assign head  = r_mem[r_rptr[AW-1:0]];
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/mf8_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : mf8_uart_rx
// Purpose  : MF8 UART receiver: 8N1 deserialiser, receive FIFO, data/status
//            registers on the IO read bus. Define MF8_UART_RX_PARITY_EN for
//            8E1 frames with even-parity checking.
// Revision : 1.0 - initial release
// ============================================================================
module mf8_uart_rx
    import mf8_uart_pkg::*;
#(
    parameter int         DIV       = 434,
    parameter int         FIFO_AW   = 2,
    parameter logic [5:0] ADDR_DATA = c_ADDR_DATA,
    parameter logic [5:0] ADDR_STAT = c_ADDR_STAT
) (
    input  logic       CLK,
    input  logic       Reset_s_n,
    input  logic       UART_RXD,
    input  logic       IO_Rd,
    input  logic [5:0] IO_Addr,
    output logic [7:0] IO_RData,
    output logic       rx_irq
);
    localparam logic [15:0] c_CNT_HALF = 16'(DIV / 2 - 1);
    localparam logic [15:0] c_CNT_BIT  = 16'(DIV - 1);

    logic [1:0]  r_sync;
    logic        w_rxd_s;
    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_bitn;
    logic [2:0]  w_bitn_nxt;
    logic [7:0]  r_shreg;
    logic [7:0]  w_shreg_nxt;
    logic        w_cnt_zero;
    logic        w_push;
    logic        w_fe_set;
    logic        w_ovr_set;
    logic        r_ovr;
    logic        r_fe;
    logic        w_rd_data;
    logic        w_rd_stat;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [7:0]  w_status;
`ifdef MF8_UART_RX_PARITY_EN
    logic        r_pe;
    logic        w_pe_set;
    logic        r_drop;
    logic        w_drop_nxt;
`endif

    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], UART_RXD};
        end
    end
    assign w_rxd_s    = r_sync[1];
    assign w_cnt_zero = (r_cnt == 16'd0);

    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_bitn  <= 3'd0;
            r_shreg <= 8'h00;
`ifdef MF8_UART_RX_PARITY_EN
            r_drop  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bitn  <= w_bitn_nxt;
            r_shreg <= w_shreg_nxt;
`ifdef MF8_UART_RX_PARITY_EN
            r_drop  <= w_drop_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 16'd1;
        w_bitn_nxt  = r_bitn;
        w_shreg_nxt = r_shreg;
        w_push      = 1'b0;
        w_fe_set    = 1'b0;
`ifdef MF8_UART_RX_PARITY_EN
        w_pe_set    = 1'b0;
        w_drop_nxt  = r_drop;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_rxd_s) begin
                    w_cnt_nxt   = c_CNT_HALF;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_cnt_zero) begin
                    if (!w_rxd_s) begin
                        w_cnt_nxt   = c_CNT_BIT;
                        w_bitn_nxt  = 3'd0;
                        w_state_nxt = ST_DATA;
`ifdef MF8_UART_RX_PARITY_EN
                        w_drop_nxt  = 1'b0;
`endif
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_cnt_zero) begin
                    w_shreg_nxt = {w_rxd_s, r_shreg[7:1]};
                    w_cnt_nxt   = c_CNT_BIT;
                    w_bitn_nxt  = r_bitn + 3'd1;
                    if (r_bitn == 3'd7) begin
`ifdef MF8_UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef MF8_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_cnt_zero) begin
                    w_cnt_nxt   = c_CNT_BIT;
                    w_state_nxt = ST_STOP;
                    // Even parity: data plus parity bit must hold an even number of ones
                    if (^{r_shreg, w_rxd_s}) begin
                        w_pe_set   = 1'b1;
                        w_drop_nxt = 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (w_cnt_zero) begin
                    if (w_rxd_s) begin
`ifdef MF8_UART_RX_PARITY_EN
                        w_push = !r_drop;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_fe_set    = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rxd_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_rd_data = IO_Rd && (IO_Addr == ADDR_DATA);
    assign w_rd_stat = IO_Rd && (IO_Addr == ADDR_STAT);
    assign w_pop     = w_rd_data && !w_empty;
    assign w_ovr_set = w_push && w_full && !w_pop;

    mf8_sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .CLK       (CLK),
        .Reset_s_n (Reset_s_n),
        .push      (w_push),
        .push_data (r_shreg),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // A flag raised in the same cycle as a status read survives the clear
    always_ff @(posedge CLK or negedge Reset_s_n) begin
        if (!Reset_s_n) begin
            r_ovr <= 1'b0;
            r_fe  <= 1'b0;
`ifdef MF8_UART_RX_PARITY_EN
            r_pe  <= 1'b0;
`endif
        end else begin
            r_ovr <= w_ovr_set | (r_ovr & ~w_rd_stat);
            r_fe  <= w_fe_set  | (r_fe  & ~w_rd_stat);
`ifdef MF8_UART_RX_PARITY_EN
            r_pe  <= w_pe_set  | (r_pe  & ~w_rd_stat);
`endif
        end
    end

    always_comb begin
        w_status               = 8'h00;
        w_status[c_STAT_AVAIL] = !w_empty;
        w_status[c_STAT_FULL]  = w_full;
        w_status[c_STAT_OVR]   = r_ovr;
        w_status[c_STAT_FE]    = r_fe;
`ifdef MF8_UART_RX_PARITY_EN
        w_status[c_STAT_PE]    = r_pe;
`endif
        w_status[c_STAT_BUSY]  = (r_state != ST_IDLE);
    end

    always_comb begin
        IO_RData = 8'h00;
        if (w_rd_data) begin
            IO_RData = w_empty ? 8'h00 : w_head;
        end else if (w_rd_stat) begin
            IO_RData = w_status;
        end
    end

    assign rx_irq = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mf8_uart_rx.sv
`default_nettype none
// Bench for mf8_uart_rx: random and directed UART frames against a byte-queue
// reference model; expected reads are queued and checked by a monitor.
module tb_mf8_uart_rx;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;

    logic       CLK       = 1'b0;
    logic       Reset_s_n = 1'b0;
    logic       UART_RXD  = 1'b1;
    logic       IO_Rd     = 1'b0;
    logic [5:0] IO_Addr   = 6'h00;
    logic [7:0] IO_RData;
    logic       rx_irq;

    mf8_uart_rx #(
        .DIV       (DIV),
        .FIFO_AW   (2),
        .ADDR_DATA (6'h00),
        .ADDR_STAT (6'h01)
    ) dut (
        .CLK       (CLK),
        .Reset_s_n (Reset_s_n),
        .UART_RXD  (UART_RXD),
        .IO_Rd     (IO_Rd),
        .IO_Addr   (IO_Addr),
        .IO_RData  (IO_RData),
        .rx_irq    (rx_irq)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // scoreboard of expected read responses
    string      exp_name_q[$];
    logic [7:0] exp_data_q[$];
    logic       exp_irq_q[$];

    // reference model: received bytes and sticky flags
    logic [7:0] mq[$];
    bit         m_ovr = 1'b0;
    bit         m_fe  = 1'b0;

    string      mon_name;
    logic [7:0] mon_data;
    logic       mon_irq;

    always @(negedge CLK) begin
        if (IO_Rd) begin
            if (exp_data_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_read: IO_RData=%h with no expectation queued", IO_RData);
            end else begin
                mon_name = exp_name_q.pop_front();
                mon_data = exp_data_q.pop_front();
                mon_irq  = exp_irq_q.pop_front();
                n_cmp++;
                if (IO_RData !== mon_data) begin
                    n_fail++;
                    $display("FAIL %s: IO_RData got %h required %h", mon_name, IO_RData, mon_data);
                end
                n_cmp++;
                if (rx_irq !== mon_irq) begin
                    n_fail++;
                    $display("FAIL %s_irq: rx_irq got %b required %b", mon_name, rx_irq, mon_irq);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic issue_read(input logic [5:0] a, input logic [7:0] ed, input string nm);
        exp_name_q.push_back(nm);
        exp_data_q.push_back(ed);
        exp_irq_q.push_back(mq.size() > 0);
        IO_Rd   = 1'b1;
        IO_Addr = a;
        tick(1);
        IO_Rd   = 1'b0;
        IO_Addr = 6'($urandom);
    endtask

    task automatic rd_data(input string nm);
        logic [7:0] e;
        e = (mq.size() > 0) ? mq[0] : 8'h00;
        issue_read(6'h00, e, nm);
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic rd_stat(input bit busy, input string nm);
        logic [7:0] e;
        e = {busy, 2'b00, 1'b0, m_fe, m_ovr, mq.size() == DEPTH, mq.size() > 0};
        issue_read(6'h01, e, nm);
        m_fe  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic rd_other(input string nm);
        issue_read(6'($urandom_range(2, 63)), 8'h00, nm);
    endtask

    // One frame, DIV cycles per bit; optionally a data read on the stop-sample
    // edge, or a reset pulse in the middle of data bit 3.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit rd_at_stop, input bit abort);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RXD = bits[i];
            if (abort && i == 4) begin
                tick(DIV / 2);
                Reset_s_n = 1'b0;
                UART_RXD  = 1'b1;
                tick(3);
                Reset_s_n = 1'b1;
                mq.delete();
                m_ovr = 1'b0;
                m_fe  = 1'b0;
                return;
            end
            if (rd_at_stop && i == 9) begin
                // start seen 3 edges after the line falls, stop sampled DIV/2 + 9*DIV later
                tick(10);
                rd_data("simul_pop");
                tick(DIV - 11);
            end else begin
                tick(DIV);
            end
        end
        if (stop) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    initial begin
        repeat (60000) @(posedge CLK);
        $display("FAIL watchdog: simulation still running after 60000 cycles, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        tick(4);
        Reset_s_n = 1'b1;
        tick(2);
        n_cmp++;
        if (IO_RData !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rdata: IO_RData got %h required 00", IO_RData);
        end
        n_cmp++;
        if (rx_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: rx_irq got %b required 0", rx_irq);
        end
        rd_stat(1'b0, "reset_stat");
        rd_data("reset_empty_data");
        rd_other("reset_other_addr");

        // clean frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        tick(2);
        rd_stat(1'b0, "clean_stat");
        rd_data("clean_data");
        rd_stat(1'b0, "clean_after");

        // start-bit glitch
        UART_RXD = 1'b0;
        tick(4);
        UART_RXD = 1'b1;
        tick(30);
        rd_stat(1'b0, "glitch_stat");

        // framing error then stuck-low line
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(100);
        UART_RXD = 1'b1;
        tick(5);
        rd_stat(1'b0, "fe_stat");
        rd_stat(1'b0, "fe_clear");

        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        tick(40);
        rd_stat(1'b1, "break_busy");
        tick(40);
        UART_RXD = 1'b1;
        tick(5);
        rd_stat(1'b0, "break_exit");

        // overrun
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b1, 1'b0, 1'b0);
            tick(2);
        end
        rd_stat(1'b0, "ovr_stat");
        for (int k = 0; k < 4; k++) rd_data("ovr_data");
        rd_data("ovr_empty_read");
        rd_stat(1'b0, "ovr_after");

        // push and pop on the same edge while full
        for (int b = 1; b <= 4; b++) begin
            send_frame(8'(b), 1'b1, 1'b0, 1'b0);
            tick(2);
        end
        rd_stat(1'b0, "simul_full_stat");
        send_frame(8'h05, 1'b1, 1'b1, 1'b0);
        tick(2);
        rd_stat(1'b0, "simul_stat");
        for (int k = 0; k < 4; k++) rd_data("simul_data");
        rd_stat(1'b0, "simul_after");

        // reset mid-frame
        send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        tick(2);
        send_frame(8'($urandom), 1'b1, 1'b0, 1'b1);
        tick(2);
        n_cmp++;
        if (rx_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_irq: rx_irq got %b required 0", rx_irq);
        end
        rd_stat(1'b0, "midreset_stat");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        tick(2);
        rd_data("midreset_data");
        rd_stat(1'b0, "midreset_after");

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
                send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
                tick(int'($urandom_range(1, 5)));
            end else if (r == 5) begin
                send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
                tick(int'($urandom_range(1, 30)));
                UART_RXD = 1'b1;
                tick(5);
            end else if (r <= 7) begin
                rd_data("rand_data");
            end else if (r == 8) begin
                rd_stat(1'b0, "rand_stat");
            end else begin
                rd_other("rand_other");
            end
        end
        rd_stat(1'b0, "final_stat");
        while (mq.size() > 0) rd_data("drain_data");
        rd_stat(1'b0, "drain_stat");

        tick(5);
        n_cmp++;
        if (exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_data_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mf8_uart_rx.md
# mf8_uart_rx

UART receiver peripheral for the MF8 soft core, the receive counterpart to the IO-write-driven TXD pin. It oversamples `UART_RXD` with a fixed clock divider, deserialises 8N1 frames, buffers bytes in a small FIFO, and exposes data and status registers on the core's IO read bus at two IO addresses.

## Interface
- `DIV`, 434: CLK cycles per bit. Legal range 4..65535.
- `FIFO_AW`, 2: log2 of the FIFO depth (default depth is 4).
- `ADDR_DATA`, 6'h00: IO address of the data register.
- `ADDR_STAT`, 6'h01: IO address of the status register.
- `CLK` in 1: core clock.
- `Reset_s_n` in 1: reset, asynchronous, active-low.
- `UART_RXD` in 1: serial input, asynchronous. Idles high.
- `IO_Rd` in 1: core IO read strobe, one cycle wide.
- `IO_Addr` in 6: core IO address.
- `IO_RData` out 8: read data. Combinational from `IO_Rd`/`IO_Addr`.
- `rx_irq` out 1: registered. High while the FIFO is not empty.

## Operation
- `UART_RXD` passes through a 2-FF synchroniser (reset value 1) to give `rxd_s`.
- A 16-bit bit counter `cnt` and a 3-bit index `bitn` drive the FSM.
- FSM states:
  - **IDLE**: on `rxd_s`=0, load `cnt`=DIV/2−1 and go to START.
  - **START**: when `cnt` reaches 0, sample `rxd_s`. If 0, load `cnt`=DIV−1, `bitn`=0, go to DATA. If 1, treat as a glitch and return to IDLE with no flag.
  - **DATA**: at each `cnt`=0, shift `rxd_s` into `shreg[7]` (LSB first), reload DIV−1. After `bitn`=7, go to PARITY (when enabled) or STOP.
  - **STOP**: at `cnt`=0, sample `rxd_s`.
    - If 1: push `shreg` and go to IDLE.
    - If 0: set FE, discard the byte, go to BREAK.
  - **BREAK**: wait for `rxd_s`=1, then go to IDLE. This stops a stuck-low line from producing a stream of framing errors.
- FIFO push when full: drop the byte and set OVR. The FIFO contents are unchanged.
- Status register bits:
  - [0] AVAIL: FIFO not empty.
  - [1] FULL.
  - [2] OVR: sticky.
  - [3] FE: sticky.
  - [4] PE: sticky, parity build only, otherwise 0.
  - [7] BUSY: FSM not in IDLE.
  - [6:5] read as 0.
- Read rules:
  - `IO_Rd`=1, `IO_Addr`=ADDR_DATA: `IO_RData` = FIFO head. If the FIFO is not empty, pop at this clock edge. If empty, return 8'h00 and leave the pointers alone.
  - `IO_Rd`=1, `IO_Addr`=ADDR_STAT: return status. OVR, FE and PE clear at this edge.
  - Any other address, or `IO_Rd`=0: `IO_RData`=8'h00.
- Simultaneous events:
  - Push and pop in the same cycle while full: both take effect, no overrun.
  - Push and pop while empty: the pop is ignored, the push takes effect.
  - Sticky flag set in the same cycle as a status read: set wins. The flag reads back 1 on the next status read.

## Timing
- Reset values:
  - `IO_RData` = 0 (no read in progress).
  - `rx_irq` = 0.
  - FIFO empty, all flags 0, FSM in IDLE, synchroniser at 1.
- Reset mid-frame abandons the partial byte with no flags set.
- Latency: from the RXD falling edge to the START check is 2 synchroniser cycles plus DIV/2 cycles. Data bit k is sampled DIV/2 + (k+1)·DIV cycles after start detection.
- Push happens at the STOP-sample edge. AVAIL and `rx_irq` are high from the next cycle.
- Pop is visible on the cycle after the read edge. `IO_RData` during the read cycle shows the pre-pop head.
- FIFO pointers are FIFO_AW+1 bits wide so full and empty can be told apart. Wrap-around is modulo 2^(FIFO_AW+1).

## Configuration
- `MF8_UART_RX_PARITY_EN` defined:
  - Adds a PARITY state after DATA that samples one bit at mid-bit.
  - Even parity is checked. On mismatch, set PE and discard the byte, then continue to STOP normally.
  - Frame format is 8E1.
- Undefined: frame format is 8N1, the PARITY state is absent and status bit [4] reads 0.

## Structure
- Shared package `mf8_uart_pkg` holds:
  - the FSM state encoding,
  - status bit index constants (AVAIL, FULL, OVR, FE, PE, BUSY),
  - default IO address constants, for reuse by the top-level IO decoder.
- One sub-module, `mf8_sync_fifo`, parameterised by width (8) and FIFO_AW. It provides push/pop/full/empty/head. Pop-when-empty and push-when-full are ignored inside it; the receiver raises OVR.

## Test plan
- **Clean frame** (DIV=16): send 0xA5 in 8N1. Then AVAIL=1 and `rx_irq`=1, DATA read returns 0xA5, and afterwards AVAIL=0 and `rx_irq`=0.
- **Start-bit glitch**: drive RXD low for 4 cycles with DIV=16. Expect IDLE with BUSY=0, no push, no flags.
- **Framing error**: send 0x3C with stop=0, hold the line low for 100 cycles, then release. Expect FE=1, FIFO empty, and a return to IDLE only after RXD goes high. A status read returns 8'h08, and the next status read returns 8'h00.
- **Overrun**: send 5 bytes 0x01..0x05 with no reads. Expect FULL=1 and OVR=1, and reads return 0x01..0x04. A read while empty returns 0x00.
- **Simultaneous push/pop when full**: issue a DATA read on the exact STOP-sample edge of byte 5. Expect OVR=0, and subsequent reads return 0x02..0x05.
- **Reset mid-frame**: deassert Reset_s_n during DATA bit 3. Expect FIFO empty, flags 0 and `rx_irq`=0. The next clean frame 0x5A is received correctly.
